// File: rtl/hypot_leg_solver_pkg.sv
// Shared definitions for hypot_leg_solver and its isqrt_step datapath.
//   state_e        : FSM state encoding (IDLE=0, SQUARE=1, ROOT=2, DONE=3)
//   DEFAULT_WIDTH  : default operand/result width
//   DEFAULT_KW     : bit-index counter width for DEFAULT_WIDTH
//   kw_for()       : counter width for an arbitrary WIDTH (at least 1 bit)
package hypot_leg_solver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_ROOT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_KW    = $clog2(DEFAULT_WIDTH);

  function automatic int kw_for(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/hypot_leg_solver_isqrt_step.sv
// One iteration of a bit-serial restoring integer square root.
//   diff_i : radicand, 2*WIDTH bits
//   res_i  : partial root built so far (bits above k already decided)
//   k_i    : bit position being decided this step
//   res_o  : res_i with bit k set if (res_i | 1<<k)^2 still fits under diff_i
// Purely combinational.
module isqrt_step #(
  parameter int WIDTH = 8,
  parameter int KW    = 3
) (
  input  logic [2*WIDTH-1:0] diff_i,
  input  logic [WIDTH-1:0]   res_i,
  input  logic [KW-1:0]      k_i,
  output logic [WIDTH-1:0]   res_o
);

  logic [WIDTH-1:0]   one;
  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH-1:0] trial_ext;
  logic [2*WIDTH-1:0] trial_sq;

  always_comb begin
    one       = {{(WIDTH-1){1'b0}}, 1'b1};
    trial     = res_i | (one << k_i);
    // Square at full 2*WIDTH so trial = 2^WIDTH-1 cannot wrap before compare.
    trial_ext = {{WIDTH{1'b0}}, trial};
    trial_sq  = trial_ext * trial_ext;
    res_o     = (trial_sq <= diff_i) ? trial : res_i;
  end

endmodule

// File: rtl/hypot_leg_solver.sv
// Computes the missing leg y = floor(sqrt(h^2 - x^2)) of a right triangle.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low freezes every register
//   start      : request, accepted only in IDLE with ena=1
//   hyp_in     : hypotenuse h, latched on accepted start
//   leg_in     : known leg x, latched on accepted start
//   result     : leg y, held until the next accepted start
//   busy       : high whenever the FSM is not IDLE
//   done       : one-cycle pulse (stretched while ena=0) when result/err valid
//   err        : x > h, held until the next accepted start
// Handshake: start is a level sampled only in IDLE with ena=1; requests made
// while busy are dropped. done rises once per accepted start and result/err
// are valid from that cycle until the next accepted start.
module hypot_leg_solver
  import hypot_leg_solver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] hyp_in,
  input  logic [WIDTH-1:0] leg_in,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW = kw_for(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hyp_q, hyp_d;
  logic [WIDTH-1:0]     leg_q, leg_d;
  logic [2*WIDTH-1:0]   diff_q, diff_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   hyp_sq;
  logic [2*WIDTH-1:0]   leg_sq;
  logic [WIDTH-1:0]     step_res;

  isqrt_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .diff_i (diff_q),
    .res_i  (result_q),
    .k_i    (k_q),
    .res_o  (step_res)
  );

  always_comb begin
    hyp_sq = {{WIDTH{1'b0}}, hyp_q} * {{WIDTH{1'b0}}, hyp_q};
    leg_sq = {{WIDTH{1'b0}}, leg_q} * {{WIDTH{1'b0}}, leg_q};
  end

  always_comb begin
    state_d  = state_q;
    hyp_d    = hyp_q;
    leg_d    = leg_q;
    diff_d   = diff_q;
    k_d      = k_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = done_q;
    if (ena) begin
      // done is registered as "next state is DONE" so it tracks the DONE state.
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            hyp_d    = hyp_in;
            leg_d    = leg_in;
            result_d = '0;
            err_d    = 1'b0;
            state_d  = ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          if (leg_q > hyp_q) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else begin
            diff_d  = hyp_sq - leg_sq;
            k_d     = KW'(WIDTH - 1);
            state_d = ST_ROOT;
          end
        end
        ST_ROOT: begin
          result_d = step_res;
          if (k_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            k_d = k_q - KW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hyp_q    <= '0;
      leg_q    <= '0;
      diff_q   <= '0;
      k_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hyp_q    <= hyp_d;
      leg_q    <= leg_d;
      diff_q   <= diff_d;
      k_q      <= k_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
